// File: rtl/ad9653_spi_seq_pkg.sv
// Shared definitions for the AD9653 SPI configuration sequencer:
// FSM state encodings, frame geometry and a frame builder.
package ad9653_spi_seq_pkg;

  localparam int FRAME_BITS = 24;
  localparam int ADDR_W     = 13;
  localparam int RW_BIT     = 23;
  localparam int W_LSB      = 21;
  localparam int ADDR_LSB   = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_INIT   = 3'd1;
  localparam state_t ST_SETUP  = 3'd2;
  localparam state_t ST_SHIFT  = 3'd3;
  localparam state_t ST_HOLD   = 3'd4;
  localparam state_t ST_GAP    = 3'd5;
  localparam state_t ST_SYNC_P = 3'd6;

  // Instruction+data word; W1W0 is always single-byte (00).
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic rd,
                                                        input logic [ADDR_W-1:0] addr,
                                                        input logic [7:0] data);
    logic [FRAME_BITS-1:0] f;
    f                     = '0;
    f[RW_BIT]             = rd;
    f[W_LSB +: 2]         = 2'b00;
    f[ADDR_LSB +: ADDR_W] = addr;
    f[7:0]                = data;
    return f;
  endfunction

endpackage

// File: rtl/ad9653_spi_shift.sv
// 24-bit SPI shift engine for the AD9653: SCLK divider, CSB framing
// (SETUP/SHIFT/HOLD/GAP) and the SDIO read turnaround.
// A go pulse loads a frame; done is high on the last GAP cycle, and a go
// in that same cycle chains the next frame with no idle cycle.
module ad9653_spi_shift
  import ad9653_spi_seq_pkg::*;
#(
  parameter int SCLK_DIV = 4
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  rw,
  input  logic                  sdio_in,
  output logic                  done,
  output logic [7:0]            rdata,
  output logic                  csb,
  output logic                  sclk,
  output logic                  sdio_out,
  output logic                  sdio_oe
);

  localparam int CNT_W = $clog2(SCLK_DIV);

  state_t           phase;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       hcnt;   // SCLK half-period index, 0..47
  logic [22:0]      sh;     // bits still to be shifted out
  logic             rd;
  logic             tick;

  assign tick = (cnt == CNT_W'(SCLK_DIV - 1));
  assign done = (phase == ST_GAP) && tick;

  // Phase sequencing, SCLK generation, SDIO drive and read capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= ST_IDLE;
      cnt      <= '0;
      hcnt     <= '0;
      sh       <= '0;
      rd       <= 1'b0;
      rdata    <= '0;
      csb      <= 1'b1;
      sclk     <= 1'b0;
      sdio_out <= 1'b0;
      sdio_oe  <= 1'b0;
    end else if (go) begin
      phase    <= ST_SETUP;
      cnt      <= '0;
      hcnt     <= '0;
      sh       <= frame[22:0];
      rd       <= rw;
      csb      <= 1'b0;
      sclk     <= 1'b0;
      sdio_out <= frame[FRAME_BITS-1];
      sdio_oe  <= 1'b1;
    end else if (phase != ST_IDLE) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        case (phase)
          ST_SETUP: begin
            phase <= ST_SHIFT;
            sclk  <= 1'b1;
          end
          ST_SHIFT: begin
            hcnt <= hcnt + 1'b1;
            if (!hcnt[0]) begin
              // end of a high half: falling edge, present next bit
              sclk <= 1'b0;
              if (hcnt != 6'd46) begin
                sdio_out <= sh[22];
                sh       <= {sh[21:0], 1'b0};
              end
              // release SDIO right after the last instruction bit
              if (rd && hcnt == 6'd30) sdio_oe <= 1'b0;
            end else if (hcnt == 6'd47) begin
              phase <= ST_HOLD;
            end else begin
              // rising edge; the last 8 carry read data
              sclk <= 1'b1;
              if (rd && hcnt >= 6'd31) rdata <= {rdata[6:0], sdio_in};
            end
          end
          ST_HOLD: begin
            phase   <= ST_GAP;
            csb     <= 1'b1;
            sdio_oe <= 1'b0;
          end
          default: phase <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ad9653_spi_seq.sv
// AD9653 SPI configuration sequencer: replays INIT_TABLE after reset or a
// start pulse, then serves single-register host reads/writes.
// Optional: define AD9653_SPI_SYNC_EN to emit a SYNC_LEN-cycle SYNC pulse
// after the init table, with init_done asserting as the pulse ends.
module ad9653_spi_seq
  import ad9653_spi_seq_pkg::*;
#(
  parameter int                      SCLK_DIV   = 4,
  parameter int                      INIT_LEN   = 8,
  parameter logic [INIT_LEN*24-1:0]  INIT_TABLE = '0,
  parameter int                      SYNC_LEN   = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  output logic              busy,
  output logic              init_done,
  output logic              csb,
  output logic              sclk,
  output logic              sdio_out,
  output logic              sdio_oe,
  input  logic              sdio_in,
  output logic              sync
);

  localparam int IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(INIT_LEN - 1);

  state_t                state;   // ST_SHIFT here means "frame in flight"
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic                  pend, cur_host, cur_rd;
  logic                  go, go_rw, done, accept, chain;
  logic [FRAME_BITS-1:0] go_frame;
  logic [7:0]            sh_rdata;
  logic [FRAME_BITS-1:0] tbl [2**IDX_W];

  // Unpack the init table, forcing W1W0 to single-byte.
  for (genvar k = 0; k < 2**IDX_W; k++) begin : g_tbl
    if (k < INIT_LEN) begin : g_ent
      assign tbl[k] = {INIT_TABLE[24*k+RW_BIT], 2'b00, INIT_TABLE[24*k +: W_LSB]};
    end else begin : g_pad
      assign tbl[k] = '0;
    end
  end

  assign idx_nxt = idx + 1'b1;
  assign accept  = (state == ST_IDLE) && init_done && !pend && !start && host_req;
  assign chain   = (state == ST_SHIFT) && done && !pend && !cur_host && (idx != LAST);
  assign busy    = (state != ST_IDLE);

  // Frame selection for the shift engine: init entry, next chained entry or host.
  always_comb begin
    go       = accept || chain || (state == ST_INIT);
    go_frame = tbl[idx];
    if (chain)
      go_frame = tbl[idx_nxt];
    else if (state == ST_IDLE)
      go_frame = make_frame(~host_we, host_addr, host_we ? host_wdata : 8'h00);
    go_rw = go_frame[RW_BIT];
  end

  ad9653_spi_shift #(.SCLK_DIV(SCLK_DIV)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .frame    (go_frame),
    .rw       (go_rw),
    .sdio_in  (sdio_in),
    .done     (done),
    .rdata    (sh_rdata),
    .csb      (csb),
    .sclk     (sclk),
    .sdio_out (sdio_out),
    .sdio_oe  (sdio_oe)
  );

`ifdef AD9653_SPI_SYNC_EN
  logic        sync_q;
  logic [15:0] scnt;
  assign sync = sync_q;
`else
  logic sync_len_unused;
  assign sync_len_unused = |SYNC_LEN;
  assign sync = 1'b0;
`endif

  // Init indexing, host arbitration, restart handling and the SYNC pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      pend       <= 1'b1;
      cur_host   <= 1'b0;
      cur_rd     <= 1'b0;
      init_done  <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
`ifdef AD9653_SPI_SYNC_EN
      sync_q     <= 1'b0;
      scnt       <= '0;
`endif
    end else begin
      host_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pend) begin
            state <= ST_INIT;
            idx   <= '0;
          end else if (accept) begin
            state    <= ST_SHIFT;
            cur_host <= 1'b1;
            cur_rd   <= ~host_we;
          end
        end
        ST_INIT: begin
          state    <= ST_SHIFT;
          pend     <= 1'b0;
          cur_host <= 1'b0;
          cur_rd   <= 1'b0;
        end
        ST_SHIFT: begin
          if (done) begin
            if (cur_host) begin
              host_ack <= 1'b1;
              if (cur_rd) host_rdata <= sh_rdata;
            end
            if (pend) begin
              state <= ST_INIT;
              idx   <= '0;
            end else if (chain) begin
              idx <= idx_nxt;
            end else if (!cur_host) begin
`ifdef AD9653_SPI_SYNC_EN
              state  <= ST_SYNC_P;
              sync_q <= 1'b1;
              scnt   <= '0;
`else
              state     <= ST_IDLE;
              init_done <= 1'b1;
`endif
            end else begin
              state <= ST_IDLE;
            end
          end
        end
`ifdef AD9653_SPI_SYNC_EN
        ST_SYNC_P: begin
          scnt <= scnt + 1'b1;
          if (scnt == 16'(SYNC_LEN - 1)) begin
            sync_q <= 1'b0;
            state  <= ST_IDLE;
            if (!pend) init_done <= 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
      // a restart request overrides any completion in the same cycle
      if (start) begin
        pend      <= 1'b1;
        init_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ad9653_spi_seq.sv
// Self-checking bench for ad9653_spi_seq: an SDIO monitor decodes frames
// into obs_q, tests push expected frames into exp_q, and an AD9653 read
// model drives sdio_in after the instruction phase.
module tb_ad9653_spi_seq;

  localparam int DIV  = 2;
  localparam int ILEN = 2;
  localparam int SLEN = 16;
  localparam logic [ILEN*24-1:0] TBL = {24'h000803, 24'h001401};
  localparam int FRAME_T = 51 * DIV;
  localparam int CSB_T   = 50 * DIV;
`ifdef AD9653_SPI_SYNC_EN
  localparam int SYNC_T = SLEN;
`else
  localparam int SYNC_T = 0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [12:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        sdio_in = 1'b0;
  logic        host_ack, busy, init_done, csb, sclk, sdio_out, sdio_oe, sync;
  logic [7:0]  host_rdata;

  int errors = 0, checks = 0;

  ad9653_spi_seq #(.SCLK_DIV(DIV), .INIT_LEN(ILEN), .INIT_TABLE(TBL), .SYNC_LEN(SLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .busy(busy), .init_done(init_done), .csb(csb),
    .sclk(sclk), .sdio_out(sdio_out), .sdio_oe(sdio_oe), .sdio_in(sdio_in), .sync(sync)
  );

  always #5 clk = ~clk;

  typedef struct { logic [23:0] fr; int nb; int w; int oe_bit; } obs_t;
  obs_t        obs_q[$];
  logic [23:0] exp_q[$];

  // monitor / AD9653 model state
  int          cyc = 0, nb = 0, nf = 0, t0 = 0, oe_bit = -1, shi = 0, sync_w = 0;
  logic        pcsb = 1'b1, psclk = 1'b0, poe = 1'b0, psync = 1'b0, pdone = 1'b0;
  logic        in_fr = 1'b0, sync_seen = 1'b0, sync_on_fall = 1'b0;
  logic [23:0] fr = '0;
  logic [7:0]  rd_byte = 8'h00;

  // Decode SDIO at each negedge; drive read data after the 16th falling edge.
  always @(negedge clk) begin
    cyc++;
    if (pcsb && !csb) begin in_fr = 1'b1; fr = '0; nb = 0; nf = 0; t0 = cyc; oe_bit = -1; end
    if (in_fr && !psclk && sclk) begin fr = {fr[22:0], sdio_oe ? sdio_out : 1'b0}; nb++; end
    if (in_fr && psclk && !sclk) nf++;
    if (in_fr && poe && !sdio_oe && !csb) oe_bit = nb;
    sdio_in = (in_fr && !sdio_oe && nf >= 16 && nf < 24) ? rd_byte[23-nf] : 1'b0;
    if (in_fr && !pcsb && csb) begin obs_q.push_back('{fr, nb, cyc - t0, oe_bit}); in_fr = 1'b0; end
    if (sync) begin sync_seen = 1'b1; if (!psync) shi = 0; shi++; end
    if (psync && !sync) begin sync_w = shi; sync_on_fall = init_done && !pdone; end
    pcsb = csb; psclk = sclk; poe = sdio_oe; psync = sync; pdone = init_done;
  end

  task automatic test_reset;
    int n; logic ok;
    rst_n = 1'b0;
    #23;
    checks++;
    if ({csb, sclk, sdio_oe, sdio_out, sync, busy, init_done, host_ack, host_rdata} !== {8'b10000000, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got csb=%b sclk=%b oe=%b out=%b sync=%b busy=%b done=%b ack=%b rdata=%h, want 1 0 0 0 0 0 0 0 00",
               csb, sclk, sdio_oe, sdio_out, sync, busy, init_done, host_ack, host_rdata);
    end
    exp_q.push_back(24'h001401);
    exp_q.push_back(24'h000803);
    @(negedge clk); rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (!csb) begin ok = 1'b1; break; end end
    checks++;
    if (!ok) begin errors++; $display("FAIL init_csb_timeout: csb never went low"); end
    ok = 1'b0; n = 0;
    for (int i = 0; i < 2000; i++) begin @(negedge clk); n++; if (init_done) begin ok = 1'b1; break; end end
    checks++;
    if (!ok || n != 2*FRAME_T + SYNC_T) begin
      errors++; $display("FAIL init_done_latency: got %0d cycles (ok=%b), want %0d", n, ok, 2*FRAME_T + SYNC_T);
    end
    while (exp_q.size() > 0) begin
      logic [23:0] e; obs_t o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL init_frame: got none, want %06h", e); end
      else begin
        o = obs_q.pop_front();
        if (o.fr !== e || o.nb != 24 || o.w != CSB_T) begin
          errors++; $display("FAIL init_frame: got %06h bits=%0d csb_low=%0d, want %06h bits=24 csb_low=%0d", o.fr, o.nb, o.w, e, CSB_T);
        end
      end
    end
  endtask

  task automatic test_host_write;
    int n; logic ok; obs_t o;
    @(negedge clk);
    host_we = 1'b1; host_addr = 13'h018; host_wdata = 8'h04; host_req = 1'b1;
    exp_q.push_back(24'h001804);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (busy) begin ok = 1'b1; break; end end
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_accept_timeout: busy never rose"); end
    ok = 1'b0; n = 0;
    for (int i = 0; i < 400; i++) begin @(negedge clk); n++; if (host_ack) begin ok = 1'b1; break; end end
    host_req = 1'b0;
    checks++;
    if (!ok || n != FRAME_T) begin errors++; $display("FAIL wr_ack_latency: got %0d (ok=%b), want %0d", n, ok, FRAME_T); end
    @(negedge clk);
    checks++;
    if (host_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse: got ack=%b busy=%b, want 0 0", host_ack, busy); end
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL wr_frame: got none, want 001804"); end
    else begin
      o = obs_q.pop_front();
      if (o.fr !== exp_q.pop_front() || o.w != CSB_T || o.oe_bit != -1) begin
        errors++; $display("FAIL wr_frame: got %06h csb_low=%0d oe_drop_bit=%0d, want 001804 %0d -1", o.fr, o.w, o.oe_bit, CSB_T);
      end
    end
  endtask

  task automatic test_host_read;
    logic ok; obs_t o;
    rd_byte = 8'h93;
    @(negedge clk);
    host_we = 1'b0; host_addr = 13'h001; host_wdata = 8'hFF; host_req = 1'b1;
    exp_q.push_back(24'h800100);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin @(negedge clk); if (host_ack) begin ok = 1'b1; break; end end
    host_req = 1'b0;
    checks++;
    if (!ok || host_rdata !== 8'h93) begin errors++; $display("FAIL rd_data_at_ack: got %h (ack=%b), want 93", host_rdata, ok); end
    repeat (5) @(negedge clk);
    checks++;
    if (host_rdata !== 8'h93) begin errors++; $display("FAIL rd_data_held: got %h, want 93", host_rdata); end
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL rd_frame: got none, want 800100"); end
    else begin
      o = obs_q.pop_front();
      if (o.fr !== exp_q.pop_front() || o.oe_bit != 16) begin
        errors++; $display("FAIL rd_frame: got %06h oe_drop_bit=%0d, want 800100 16", o.fr, o.oe_bit);
      end
    end
  endtask

  task automatic test_start_mid;
    logic ok;
    @(negedge clk);
    host_we = 1'b1; host_addr = 13'h018; host_wdata = 8'h55; host_req = 1'b1;
    exp_q.push_back(24'h001855);
    exp_q.push_back(24'h001401);
    exp_q.push_back(24'h000803);
    repeat (20) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    checks++;
    if (init_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL start_clears_done: got done=%b busy=%b, want 0 1", init_done, busy); end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin @(negedge clk); if (host_ack) begin ok = 1'b1; break; end end
    host_req = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL start_host_ack: got no ack, want ack"); end
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin @(negedge clk); if (init_done) begin ok = 1'b1; break; end end
    checks++;
    if (!ok) begin errors++; $display("FAIL start_reinit_timeout: init_done never returned"); end
    while (exp_q.size() > 0) begin
      logic [23:0] e; obs_t o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL start_frame: got none, want %06h", e); end
      else begin
        o = obs_q.pop_front();
        if (o.fr !== e || o.nb != 24) begin errors++; $display("FAIL start_frame: got %06h bits=%0d, want %06h 24", o.fr, o.nb, e); end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic ok; int n;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (in_fr && nb == 10) begin ok = 1'b1; break; end end
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_bit10_timeout: never reached bit 10"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (csb !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got csb=%b sclk=%b busy=%b, want 1 0 0", csb, sclk, busy);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].nb >= 24) begin
      errors++; $display("FAIL rstmid_partial: got %0d records, want 1 partial frame", obs_q.size());
    end
    obs_q.delete();
    exp_q.push_back(24'h001401);
    exp_q.push_back(24'h000803);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (!csb) begin ok = 1'b1; break; end end
    ok = ok && 1'b1; n = 0;
    for (int i = 0; i < 2000 && ok; i++) begin @(negedge clk); n++; if (init_done) break; end
    checks++;
    if (!ok || n != 2*FRAME_T + SYNC_T) begin errors++; $display("FAIL rstmid_reinit: got %0d cycles (ok=%b), want %0d", n, ok, 2*FRAME_T + SYNC_T); end
    while (exp_q.size() > 0) begin
      logic [23:0] e; obs_t o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL rstmid_frame: got none, want %06h", e); end
      else begin
        o = obs_q.pop_front();
        if (o.fr !== e || o.nb != 24) begin errors++; $display("FAIL rstmid_frame: got %06h bits=%0d, want %06h 24", o.fr, o.nb, e); end
      end
    end
  endtask

  task automatic test_sync;
    logic ok;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin @(negedge clk); if (init_done) begin ok = 1'b1; break; end end
    checks++;
    if (!ok) begin errors++; $display("FAIL sync_init_timeout: init_done never rose"); end
    obs_q.delete();
`ifdef AD9653_SPI_SYNC_EN
    checks++;
    if (sync_w != SLEN || sync_on_fall !== 1'b1) begin
      errors++; $display("FAIL sync_pulse: got width=%0d done_on_fall=%b, want %0d 1", sync_w, sync_on_fall, SLEN);
    end
`else
    checks++;
    if (sync_seen !== 1'b0) begin errors++; $display("FAIL sync_tied_low: got sync_seen=%b, want 0", sync_seen); end
`endif
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_host_read();
    test_start_mid();
    test_reset_mid();
    test_sync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
